// File: rtl/clint_if.sv
`default_nettype none
// ============================================================================
// Module      : clint_if
// Description : Single-beat request/acknowledge register port used by the
//               core to reach the CLINT timer and software-interrupt
//               registers.
// Revision    : 1.0 - initial release
// ============================================================================
interface clint_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface
`default_nettype wire

// File: rtl/clint.sv
`default_nettype none
// ============================================================================
// Module      : clint
// Description : Core-local interruptor. Holds the 64-bit mtime counter
//               (advanced by a TICK_DIV prescaler), the 64-bit mtimecmp
//               register and the msip bit, and drives the registered machine
//               timer and software interrupt lines. Registers are reached
//               through a two-state (IDLE/ACK) request/acknowledge port.
//               Optional feature macro: CLINT_MTIME_LATCH_EN - a read of
//               mtime lo snapshots mtime hi so the following hi read is
//               tear-free.
// Revision    : 1.0 - initial release
// ============================================================================
module clint #(
  parameter int unsigned TICK_DIV = 1
) (
  input  wire     clk_i,
  input  wire     rst_ni,
  clint_if.slave  bus,
  output logic    timer_irq_o,
  output logic    software_irq_o
);

  // Word offsets (byte offset >> 2) of the mapped registers
  localparam logic [13:0] c_ADDR_MSIP    = 14'h0000;  // 0x0000
  localparam logic [13:0] c_ADDR_CMP_LO  = 14'h1000;  // 0x4000
  localparam logic [13:0] c_ADDR_CMP_HI  = 14'h1001;  // 0x4004
  localparam logic [13:0] c_ADDR_TIME_LO = 14'h2FFE;  // 0xBFF8
  localparam logic [13:0] c_ADDR_TIME_HI = 14'h2FFF;  // 0xBFFC

  localparam logic [15:0] c_TICK_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_ack;
  logic [31:0] r_rdata;
  logic [15:0] r_prescale;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_timer_irq;
  logic        r_sw_irq;

  logic [13:0] w_word;
  logic        w_access;
  logic        w_wr;
  logic        w_tick;
  logic        w_wr_msip;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_time_lo;
  logic        w_wr_time_hi;
  logic [31:0] w_time_hi_rd;
  logic [31:0] w_rd_data;
  logic        w_unused;

  // Byte lanes are not supported, so the low address bits carry no meaning
  assign w_unused = ^bus.addr[1:0];

  assign w_word   = bus.addr[15:2];
  // Requests are only taken in IDLE; anything arriving during ACK is ignored
  assign w_access = (r_state == IDLE) && bus.req;
  assign w_wr     = w_access && bus.we;
  assign w_tick   = (r_prescale == c_TICK_LAST);

  assign w_wr_msip    = w_wr && (w_word == c_ADDR_MSIP);
  assign w_wr_cmp_lo  = w_wr && (w_word == c_ADDR_CMP_LO);
  assign w_wr_cmp_hi  = w_wr && (w_word == c_ADDR_CMP_HI);
  assign w_wr_time_lo = w_wr && (w_word == c_ADDR_TIME_LO);
  assign w_wr_time_hi = w_wr && (w_word == c_ADDR_TIME_HI);

`ifdef CLINT_MTIME_LATCH_EN
  logic [31:0] r_shadow_hi;
  logic        r_shadow_vld;

  // Snapshot mtime hi on a lo read; any other access drops the snapshot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow_hi  <= '0;
      r_shadow_vld <= 1'b0;
    end else if (w_access) begin
      if (!bus.we && (w_word == c_ADDR_TIME_LO)) begin
        r_shadow_hi  <= r_mtime[63:32];
        r_shadow_vld <= 1'b1;
      end else begin
        r_shadow_vld <= 1'b0;
      end
    end
  end

  assign w_time_hi_rd = r_shadow_vld ? r_shadow_hi : r_mtime[63:32];
`else
  assign w_time_hi_rd = r_mtime[63:32];
`endif

  // Read multiplexer; unmapped offsets read as zero
  always_comb begin
    w_rd_data = '0;
    case (w_word)
      c_ADDR_MSIP:    w_rd_data = {31'd0, r_msip};
      c_ADDR_CMP_LO:  w_rd_data = r_mtimecmp[31:0];
      c_ADDR_CMP_HI:  w_rd_data = r_mtimecmp[63:32];
      c_ADDR_TIME_LO: w_rd_data = r_mtime[31:0];
      c_ADDR_TIME_HI: w_rd_data = w_time_hi_rd;
      default:        w_rd_data = '0;
    endcase
  end

  // Bus FSM: perform the access in IDLE, pulse ack for one cycle in ACK
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            r_rdata <= bus.we ? 32'd0 : w_rd_data;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Free-running prescaler; never disturbed by mtime writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prescale <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + 16'd1;
    end
  end

  // mtime: a write to either half takes priority over a coincident tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtime <= '0;
    end else if (w_wr_time_lo) begin
      r_mtime[31:0] <= bus.wdata;
    end else if (w_wr_time_hi) begin
      r_mtime[63:32] <= bus.wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp and msip software-visible registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else begin
      if (w_wr_cmp_lo) r_mtimecmp[31:0]  <= bus.wdata;
      if (w_wr_cmp_hi) r_mtimecmp[63:32] <= bus.wdata;
      if (w_wr_msip)   r_msip            <= bus.wdata[0];
    end
  end

  // Interrupt lines are registered from the current register values
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timer_irq <= 1'b0;
      r_sw_irq    <= 1'b0;
    end else begin
      r_timer_irq <= (r_mtime >= r_mtimecmp);
      r_sw_irq    <= r_msip;
    end
  end

  assign bus.ack        = r_ack;
  assign bus.rdata      = r_rdata;
  assign timer_irq_o    = r_timer_irq;
  assign software_irq_o = r_sw_irq;

endmodule
`default_nettype wire

// File: tb/tb_clint.sv
`default_nettype none
// ============================================================================
// Module      : tb_clint
// Description : Self-checking bench for clint. Two instances (TICK_DIV=1 and
//               TICK_DIV=4) share clock and reset. A vector table covers the
//               register map; hand-written sequences cover prescaling, timer
//               compare, carry/wrap, the mtime hi latch and reset mid-access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clint;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic tirq1, sirq1, tirq4, sirq4;

  clint_if bus1 ();
  clint_if bus4 ();

  clint #(.TICK_DIV(1)) dut1 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus1),
    .timer_irq_o    (tirq1),
    .software_irq_o (sirq1)
  );

  clint #(.TICK_DIV(4)) dut4 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus4),
    .timer_irq_o    (tirq4),
    .software_irq_o (sirq4)
  );

  always #5 clk = ~clk;

  // Edge counter; read #1 after an edge it holds that edge's index
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          s4;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_sw;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vt [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus transaction. 'at' is the index of the edge that sampled req.
  task automatic access(input bit s4, input bit we, input logic [15:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int unsigned at);
    logic        ack_a, ack_b;
    logic [31:0] rd_b;
    @(negedge clk);
    if (s4) begin
      bus4.req = 1'b1; bus4.we = we; bus4.addr = a; bus4.wdata = wd;
    end else begin
      bus1.req = 1'b1; bus1.we = we; bus1.addr = a; bus1.wdata = wd;
    end
    @(posedge clk); #1;
    at    = cyc;
    ack_a = s4 ? bus4.ack : bus1.ack;
    rd    = s4 ? bus4.rdata : bus1.rdata;
    bus1.req = 1'b0;
    bus4.req = 1'b0;
    @(posedge clk); #1;
    ack_b = s4 ? bus4.ack : bus1.ack;
    rd_b  = s4 ? bus4.rdata : bus1.rdata;
    check($sformatf("ack_pulse@%h", a), {62'd0, ack_a, ack_b}, 64'b10);
    check($sformatf("rdata_after_ack@%h", a), rd_b, 64'd0);
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] rd, rd2;
    int unsigned at, a0;

    vt[0]  = '{0, 0, 16'h0000, 32'h0,        32'h0000_0000, 0};
    vt[1]  = '{0, 0, 16'h4000, 32'h0,        32'hFFFF_FFFF, 0};
    vt[2]  = '{0, 0, 16'h4004, 32'h0,        32'hFFFF_FFFF, 0};
    vt[3]  = '{0, 0, 16'hBFFC, 32'h0,        32'h0000_0000, 0};
    vt[4]  = '{0, 0, 16'h1234, 32'h0,        32'h0000_0000, 0};
    vt[5]  = '{0, 1, 16'h1234, 32'hDEADBEEF, 32'h0000_0000, 0};
    vt[6]  = '{0, 0, 16'h1234, 32'h0,        32'h0000_0000, 0};
    vt[7]  = '{0, 1, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vt[8]  = '{0, 0, 16'h0000, 32'h0,        32'h0000_0001, 1};
    vt[9]  = '{0, 0, 16'h0003, 32'h0,        32'h0000_0001, 1};
    vt[10] = '{0, 1, 16'h0000, 32'h0,        32'h0000_0000, 0};
    vt[11] = '{0, 0, 16'h0000, 32'h0,        32'h0000_0000, 0};
    vt[12] = '{0, 1, 16'h4004, 32'h12345678, 32'h0000_0000, 0};
    vt[13] = '{0, 0, 16'h4004, 32'h0,        32'h1234_5678, 0};
    vt[14] = '{0, 0, 16'h4008, 32'h0,        32'h0000_0000, 0};
    vt[15] = '{0, 1, 16'h4004, 32'hFFFF_FFFF, 32'h0000_0000, 0};
    vt[16] = '{0, 1, 16'h4000, 32'h0000_0005, 32'h0000_0000, 0};
    vt[17] = '{0, 0, 16'h4000, 32'h0,        32'h0000_0005, 0};
    vt[18] = '{0, 1, 16'h4000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
    vt[19] = '{1, 0, 16'h4000, 32'h0,        32'hFFFF_FFFF, 0};
    vt[20] = '{1, 1, 16'h0000, 32'h0000_0001, 32'h0000_0000, 1};
    vt[21] = '{1, 0, 16'h0000, 32'h0,        32'h0000_0001, 1};
    vt[22] = '{1, 1, 16'h0000, 32'hFFFF_FFFE, 32'h0000_0000, 0};
    vt[23] = '{1, 0, 16'h0000, 32'h0,        32'h0000_0000, 0};
    vt[24] = '{1, 0, 16'hBFFC, 32'h0,        32'h0000_0000, 0};

    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    bus4.req = 1'b0; bus4.we = 1'b0; bus4.addr = '0; bus4.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {62'd0, bus1.ack, bus4.ack}, 64'd0);
    check("rst_rdata", bus1.rdata | bus4.rdata, 64'd0);
    check("rst_irqs", {60'd0, tirq1, sirq1, tirq4, sirq4}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mtime lo small and monotonic: two reads 2 edges apart differ by 2
    access(0, 0, 16'hBFF8, 32'h0, rd, at);
    access(0, 0, 16'hBFF8, 32'h0, rd2, at);
    checks++;
    if (rd >= 32'd64) begin
      failures++;
      $display("FAIL mtime_small: got %0d expected below 64", rd);
    end
    check("mtime_monotonic", rd2 - rd, 64'd2);
    check("irqs_after_reset", {60'd0, tirq1, sirq1, tirq4, sirq4}, 64'd0);

    // Register map vectors
    for (int i = 0; i < NVEC; i++) begin
      access(vt[i].s4, vt[i].we, vt[i].addr, vt[i].wdata, rd, at);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_sw_irq", i), vt[i].s4 ? sirq4 : sirq1, vt[i].exp_sw);
    end

    // TICK_DIV=4: about one increment per 4 cycles
    access(1, 1, 16'hBFF8, 32'h0, rd, at);
    repeat (40) begin
      @(posedge clk); #1;
    end
    access(1, 0, 16'hBFF8, 32'h0, rd, at);
    checks++;
    if (!(rd >= 32'd9 && rd <= 32'd11)) begin
      failures++;
      $display("FAIL tdiv4_rate: got %0d expected 9..11", rd);
    end

    // Timer compare: mtime=0 at edge a0, mtimecmp=0x20
    access(0, 1, 16'hBFF8, 32'h0, rd, a0);
    access(0, 1, 16'h4000, 32'h20, rd, at);
    access(0, 1, 16'h4004, 32'h0, rd, at);
    wait_until(a0 + 32);
    check("tirq_before_match", tirq1, 64'd0);
    @(posedge clk); #1;
    check("tirq_rise", tirq1, 64'd1);
    access(0, 1, 16'h4000, 32'hFFFF_FFFF, rd, at);
    check("tirq_fall_after_lo", tirq1, 64'd0);
    access(0, 1, 16'h4004, 32'hFFFF_FFFF, rd, at);
    check("tirq_low_after_hi", tirq1, 64'd0);

    // Carry from lo into hi
    access(0, 1, 16'hBFFC, 32'h0, rd, at);
    access(0, 1, 16'hBFF8, 32'hFFFF_FFFE, rd, a0);
    wait_until(a0 + 2);
    access(0, 0, 16'hBFF8, 32'h0, rd, at);
    check("carry_lo", rd, 64'd0);
    access(0, 0, 16'hBFFC, 32'h0, rd, at);
    check("carry_hi", rd, 64'd1);

    // 64-bit wrap; mtime == mtimecmp (all ones) raises the irq for one value
    access(0, 1, 16'hBFFC, 32'hFFFF_FFFF, rd, at);
    access(0, 1, 16'hBFF8, 32'hFFFF_FFFF, rd, at);
    check("tirq_equal", tirq1, 64'd1);
    access(0, 0, 16'hBFF8, 32'h0, rd, at);
    check("wrap_lo", rd, 64'd0);
    check("tirq_after_wrap", tirq1, 64'd0);
    access(0, 0, 16'hBFFC, 32'h0, rd, at);
    check("wrap_hi", rd, 64'd0);

    // mtime hi latch: lo read snapshots hi
    access(0, 1, 16'hBFFC, 32'h0, rd, at);
    access(0, 1, 16'hBFF8, 32'hFFFF_FFF0, rd, at);
    access(0, 0, 16'hBFF8, 32'h0, rd, at);
    check("latch_lo", rd, 64'hFFFF_FFF1);
    repeat (32) begin
      @(posedge clk); #1;
    end
    access(0, 0, 16'hBFFC, 32'h0, rd, at);
`ifdef CLINT_MTIME_LATCH_EN
    check("latch_hi", rd, 64'd0);
`else
    check("latch_hi", rd, 64'd1);
`endif
    access(0, 0, 16'hBFF8, 32'h0, rd, at);
    access(0, 0, 16'h0000, 32'h0, rd, at);
    access(0, 0, 16'hBFFC, 32'h0, rd, at);
    check("latch_invalidated_hi", rd, 64'd1);

    // Reset in the middle of an access drops the pending ack
    access(0, 1, 16'h0000, 32'h1, rd, at);
    check("sw_irq_before_reset", sirq1, 64'd1);
    @(negedge clk);
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 16'h4000;
    @(posedge clk); #1;
    check("midreset_ack_seen", bus1.ack, 64'd1);
    bus1.req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_ack_dropped", bus1.ack, 64'd0);
    check("midreset_rdata", bus1.rdata, 64'd0);
    check("midreset_sw_irq", sirq1, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 0, 16'h0000, 32'h0, rd, at);
    check("reissue_msip", rd, 64'd0);
    access(0, 0, 16'h4000, 32'h0, rd, at);
    check("reissue_cmp_lo", rd, 64'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
